sram_mem_responder: RTL and testbench
=====================================

Name: sram_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data access: accepts word read/write requests (rd_en/wr_en, byte address, write data) and services them on an external 16-bit asynchronous SRAM as two halfword accesses.
- Drives ready low while a request is in flight so the pipeline freezes; ready pulses high for one cycle when the access completes.
- Sits between the MEM stage and the board SRAM pins, replacing the single-cycle register-file data memory.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ACCESS_CYCLES, 2: cycles per halfword access; minimum 2.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_en  in  1  word read request; held by the frozen pipeline until ready=1.
- wr_en  in  1  word write request; held until ready=1.
- address  in  32  byte address from ALU result.
- write_data  in  32  store data (Rm value).
- read_data  out  32  last completed read word.
- ready  out  1  1 = no request pending or access completing this cycle.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_out  out  16  write data to pad.
- sram_dq_oe  out  1  pad output enable.
- sram_dq_in  in  16  read data from pad.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Address mapping:
  - word_idx = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits (wraps modulo, no error).
  - Low half at sram_addr = {word_idx, 0}; high half at {word_idx, 1}.
  - address[1:0] ignored.
- FSM states: IDLE, LO, HI, DONE. Counter cnt counts 0..ACCESS_CYCLES-1, width $clog2(ACCESS_CYCLES).
- State transitions:
  - IDLE: if (rd_en|wr_en), latch op (write wins if both), word_idx and write_data; go to LO with cnt=0.
  - LO: cnt increments; on cnt==ACCESS_CYCLES-1 go to HI with cnt=0.
  - HI: same counting; on cnt==ACCESS_CYCLES-1 go to DONE.
  - DONE: one cycle, then IDLE unconditionally. The request seen next in IDLE is the next instruction's request.
- ready is combinational: ready = ~(rd_en|wr_en) when in IDLE; 0 in LO/HI; 1 in DONE.
- Latency: request first visible in cycle 0 gives ready=1 in cycle 1+2*ACCESS_CYCLES (cycle 5 at default).
- Read access:
  - sram_oe_n=0 and sram_dq_oe=0 throughout LO/HI.
  - Capture sram_dq_in into read_data[15:0] on the last LO cycle edge, and into read_data[31:16] on the last HI cycle edge.
  - read_data is valid in DONE and holds until the next read's LO capture.
- Write access:
  - sram_dq_oe=1 during LO/HI; sram_dq_out = latched data[15:0] in LO and [31:16] in HI.
  - sram_we_n=0 for cycles cnt<ACCESS_CYCLES-1 of each half, and 1 on the last cycle of each half (data/address hold).
  - read_data is unchanged.
- Outside active states: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0; sram_addr holds its last value.
- Request deasserted mid-access: the access still completes, and DONE still pulses ready.
- Address or data changing mid-access: ignored; latched values are used.
- Reset (asynchronous, any state): state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - ready then follows the IDLE rule.
  - An aborted write may leave one halfword written; this is acceptable.

Test Plan:
- Reset then idle, rd_en=wr_en=0 -> ready=1, we_n=oe_n=1, dq_oe=0, read_data=0.
- Write 0xDEADBEEF to address 1028, held until ready -> ready low cycles 0-4, high cycle 5. SRAM model shows [2]=0xBEEF and [3]=0xDEAD. we_n low exactly 1 cycle per half, with dq_oe=1.
- Read address 1028 after that write -> sram_addr 2 then 3, read_data=0xDEADBEEF in cycle 5, ready pulse 1 cycle, then it returns to idle.
- Back-to-back: read held through DONE, then a new write presented the next cycle -> the second access starts from IDLE with no lost or duplicated request, and each gets exactly one ready pulse.
- rd_en=wr_en=1 at address 1024 with data 0x12345678 -> a write occurs, read_data unchanged.
- Assert rst low during HI of a write -> outputs reach reset values immediately without a clock edge. After release, a new read of 1024 completes normally in 5 cycles.

Source files
------------

// File: rtl/sram_mem_responder.sv
// MEM-stage data responder: turns one 32-bit load/store into two halfword
// accesses on a 16-bit asynchronous SRAM and holds ready low until both are done.
module sram_mem_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic [1:0]         o_dbg_state
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_is_wr;
    logic [SRAM_AW-2:0] r_word_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic [SRAM_AW-1:0] r_sram_addr;

    logic               w_req;
    logic               w_last;
    logic               w_active;
    logic [SRAM_AW-2:0] w_word_idx;

    assign w_req      = rd_en | wr_en;
    assign w_last     = (r_cnt == LAST);
    assign w_active   = (r_state == S_LO) || (r_state == S_HI);
    // Offset out of range simply wraps inside the SRAM; address[1:0] falls off in the shift.
    assign w_word_idx = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_req) w_state_nxt = S_LO;
            end
            S_LO: begin
                if (w_last) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Request latch, SRAM address and read capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr     <= 1'b0;
            r_word_idx  <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_is_wr     <= wr_en;
                r_word_idx  <= w_word_idx;
                r_wdata     <= write_data;
                r_sram_addr <= {w_word_idx, 1'b0};
            end
            if (r_state == S_LO && w_last) begin
                r_sram_addr <= {r_word_idx, 1'b1};
                if (!r_is_wr) r_read_data[15:0] <= sram_dq_in;
            end
            if (r_state == S_HI && w_last && !r_is_wr) begin
                r_read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // Output logic; we_n rises on the last cycle of each half so address/data hold past the strobe
    always_comb begin
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        case (r_state)
            S_IDLE: ready = ~w_req;
            S_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
        if (w_active) begin
            if (r_is_wr) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = w_last;
                sram_dq_out = (r_state == S_LO) ? r_wdata[15:0] : r_wdata[31:16];
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder with a small behavioural SRAM on the pins.
module tb_sram_mem_responder;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_fail;

    logic [15:0] mem [16];

    sram_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: writes land at the clock edge that ends a we_n-low cycle
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] f_idx(input logic [31:0] a);
        logic [31:0] t;
        t = (a - 32'd1024) >> 2;
        return t[16:0];
    endfunction

    // Presents a request in cycle 0 and walks it to DONE (cycle 5); request left as-is afterwards
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic drop_mid);
        logic [16:0] idx;
        int          we_lo;
        idx   = f_idx(a);
        we_lo = 0;
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk({tag, "_ready_low"}, ready, 32'd0);
            if (c >= 1) begin
                chk({tag, "_addr"}, sram_addr, {idx, (c >= 3) ? 1'b1 : 1'b0});
                if (wr) begin
                    chk({tag, "_dq_oe"}, sram_dq_oe, 32'd1);
                    chk({tag, "_dq_out"}, sram_dq_out, (c < 3) ? d[15:0] : d[31:16]);
                    chk({tag, "_we_n"}, sram_we_n, (c == 1 || c == 3) ? 32'd0 : 32'd1);
                end else begin
                    chk({tag, "_oe_n"}, sram_oe_n, 32'd0);
                    chk({tag, "_dq_oe_rd"}, sram_dq_oe, 32'd0);
                end
            end
            if (!sram_we_n) we_lo++;
            if (c == 2) begin
                address    = a ^ 32'h0000_0040;
                write_data = ~d;
                if (drop_mid) begin
                    rd_en = 1'b0;
                    wr_en = 1'b0;
                end
            end
            @(posedge clk); #2;
        end
        chk({tag, "_ready_done"}, ready, 32'd1);
        chk({tag, "_we_count"}, we_lo, wr ? 32'd2 : 32'd0);
        chk({tag, "_done_oe_n"}, sram_oe_n, 32'd1);
        chk({tag, "_done_dq_oe"}, sram_dq_oe, 32'd0);
    endtask

    task automatic go_idle(input string tag);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        chk({tag, "_idle_ready"}, ready, 32'd1);
        chk({tag, "_idle_we_n"}, sram_we_n, 32'd1);
        chk({tag, "_idle_oe_n"}, sram_oe_n, 32'd1);
        chk({tag, "_idle_dq_oe"}, sram_dq_oe, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_ready", ready, 32'd1);
        chk("rst_we_n", sram_we_n, 32'd1);
        chk("rst_oe_n", sram_oe_n, 32'd1);
        chk("rst_dq_oe", sram_dq_oe, 32'd0);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_addr", sram_addr, 32'h0);
        chk("rst_state", dbg_state, 32'd0);

        run_req("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        chk("wr1028_mem2", mem[2], 32'h0000BEEF);
        chk("wr1028_mem3", mem[3], 32'h0000DEAD);
        chk("wr1028_rd_keep", read_data, 32'h0);
        go_idle("wr1028");

        run_req("rd1028", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        chk("rd1028_data", read_data, 32'hDEADBEEF);
        go_idle("rd1028");

        // Read held through DONE, write presented the very next cycle
        run_req("b2b_rd", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        chk("b2b_rd_data", read_data, 32'hDEADBEEF);
        run_req("b2b_wr", 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
        chk("b2b_mem4", mem[4], 32'h0000F00D);
        chk("b2b_mem5", mem[5], 32'h0000CAFE);
        chk("b2b_rd_keep", read_data, 32'hDEADBEEF);
        go_idle("b2b");

        run_req("both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        chk("both_mem0", mem[0], 32'h00005678);
        chk("both_mem1", mem[1], 32'h00001234);
        chk("both_rd_keep", read_data, 32'hDEADBEEF);
        go_idle("both");

        // Below BASE_ADDR wraps to the top word; request dropped mid-access
        run_req("wrap", 1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 1'b1);
        chk("wrap_mem14", mem[14], 32'h0000C0DE);
        chk("wrap_mem15", mem[15], 32'h00000BAD);
        go_idle("wrap");

        // Reset during the HI half of a write, away from any clock edge
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hAAAA5555;
        repeat (3) @(posedge clk);
        #2;
        chk("rsthi_state", dbg_state, 32'd2);
        chk("rsthi_we_n", sram_we_n, 32'd0);
        rst = 1'b0;
        #1;
        chk("rsthi_addr", sram_addr, 32'h0);
        chk("rsthi_we_n_rst", sram_we_n, 32'd1);
        chk("rsthi_oe_n_rst", sram_oe_n, 32'd1);
        chk("rsthi_dq_oe_rst", sram_dq_oe, 32'd0);
        chk("rsthi_dq_out_rst", sram_dq_out, 32'h0);
        chk("rsthi_read_data", read_data, 32'h0);
        chk("rsthi_ready_req", ready, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("rsthi_ready_idle", ready, 32'd1);
        @(negedge clk) rst = 1'b1;

        run_req("rd1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        chk("rd1024_data", read_data, 32'h12345678);
        go_idle("rd1024");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
